// File: rtl/bcd_pkg.sv
// Shared BCD digit constants and helpers for the multi-decade counter.
// bcd_step wraps 9->0 going up and 0->9 going down.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    function automatic logic bcd_valid(input logic [3:0] d);
        return (d <= BCD_MAX);
    endfunction

    function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic up);
        logic [3:0] nxt;
        if (up) begin
            nxt = (d >= BCD_MAX) ? BCD_MIN : d + 4'd1;
        end else begin
            nxt = (d == BCD_MIN) ? BCD_MAX : d - 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: sanitising parallel load, enabled up/down step,
// per-digit terminal count and a registered load-error flag.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       CLK,
    input  logic       CLR,
    input  logic       EN,
    input  logic       UP,
    input  logic       LOAD,
    input  logic [3:0] D,
    output logic [3:0] Q,
    output logic       DTC,
    output logic       DERR
);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            Q    <= BCD_MIN;
            DERR <= 1'b0;
        end else begin
            DERR <= LOAD & ~bcd_valid(D);
            if (LOAD) begin
                // Non-BCD load digits are forced to zero so Q never holds A..F.
                Q <= bcd_valid(D) ? D : BCD_MIN;
            end else if (EN) begin
                Q <= bcd_step(Q, UP);
            end
        end
    end

    assign DTC = UP ? (Q == BCD_MAX) : (Q == BCD_MIN);

endmodule

// File: rtl/bcd_cnt_n.sv
// Multi-decade synchronous BCD up/down counter. Carries ripple as clock
// enables through an AND chain; every decade shares CLK.
module bcd_cnt_n
    import bcd_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int CEO_REG = 0
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  CE,
    input  logic                  UP,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   D,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  TC,
    output logic                  CEO,
    output logic                  LD_ERR
);

    logic [DIGITS-1:0] en;
    logic [DIGITS-1:0] dtc;
    logic [DIGITS-1:0] derr;
    logic              ceo_term;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign en[i] = CE;
        end else begin : g_chain
            assign en[i] = en[i-1] & dtc[i-1];
        end

        bcd_digit u_digit (
            .CLK  (CLK),
            .CLR  (CLR),
            .EN   (en[i]),
            .UP   (UP),
            .LOAD (LOAD),
            .D    (D[4*i+3:4*i]),
            .Q    (Q[4*i+3:4*i]),
            .DTC  (dtc[i]),
            .DERR (derr[i])
        );
    end

    assign TC       = &dtc;
    assign LD_ERR   = |derr;
    assign ceo_term = CE & ~LOAD & ~CLR & TC;

    if (CEO_REG != 0) begin : g_ceo_reg
        // Pulse lands in the cycle after the full-scale wrap edge.
        logic ceo_q;
        always_ff @(posedge CLK) begin
            if (CLR) begin
                ceo_q <= 1'b0;
            end else begin
                ceo_q <= ceo_term;
            end
        end
        assign CEO = ceo_q;
    end else begin : g_ceo_comb
        assign CEO = ceo_term;
    end

endmodule

// File: tb/tb_bcd_cnt_n.sv
// Bench for bcd_cnt_n: a 2-digit counter, a cascaded pair forming 4 digits,
// and a registered-CEO variant, all checked against a behavioural model.
module tb_bcd_cnt_n;

  logic       CLK;
  logic       CLR, CE, UP, LOAD;
  logic [7:0] D, DB;

  logic [7:0] q_a, q_b, q_r;
  logic       tc_a, tc_b, tc_r;
  logic       ceo_a, ceo_b, ceo_r;
  logic       lderr_a, lderr_b, lderr_r;

  int checks = 0;
  int failures = 0;

  logic [26:0] exp_q[$];

  logic [7:0]  m_a;
  logic [15:0] m_c;
  logic        m_err_a, m_err_b, m_ceor;

  bcd_cnt_n #(.DIGITS(2), .CEO_REG(0)) u_a (
    .CLK(CLK), .CLR(CLR), .CE(CE), .UP(UP), .LOAD(LOAD), .D(D),
    .Q(q_a), .TC(tc_a), .CEO(ceo_a), .LD_ERR(lderr_a)
  );

  bcd_cnt_n #(.DIGITS(2), .CEO_REG(0)) u_b (
    .CLK(CLK), .CLR(CLR), .CE(ceo_a), .UP(UP), .LOAD(LOAD), .D(DB),
    .Q(q_b), .TC(tc_b), .CEO(ceo_b), .LD_ERR(lderr_b)
  );

  bcd_cnt_n #(.DIGITS(2), .CEO_REG(1)) u_r (
    .CLK(CLK), .CLR(CLR), .CE(CE), .UP(UP), .LOAD(LOAD), .D(D),
    .Q(q_r), .TC(tc_r), .CEO(ceo_r), .LD_ERR(lderr_r)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // behavioural model
  function automatic logic [31:0] m_next(input logic [31:0] q, input int n,
                                         input bit clr, ld, ce, up,
                                         input logic [31:0] d);
    logic [31:0] r;
    logic [3:0]  dig;
    bit          en;
    r = q;
    en = ce;
    for (int i = 0; i < 8; i++) begin
      if (i < n) begin
        dig = q[4*i +: 4];
        if (clr) r[4*i +: 4] = 4'd0;
        else if (ld) r[4*i +: 4] = (d[4*i +: 4] > 4'd9) ? 4'd0 : d[4*i +: 4];
        else if (en) begin
          if (up) r[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
          else    r[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
        end
        en = en && (up ? (dig == 4'd9) : (dig == 4'd0));
      end
    end
    return r;
  endfunction

  function automatic bit m_tc(input logic [31:0] q, input int n, input bit up);
    bit t;
    t = 1'b1;
    for (int i = 0; i < 8; i++)
      if (i < n) t = t && (up ? (q[4*i +: 4] == 4'd9) : (q[4*i +: 4] == 4'd0));
    return t;
  endfunction

  function automatic bit m_bad(input logic [7:0] d);
    return (d[3:0] > 4'd9) || (d[7:4] > 4'd9);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // driver: one clock cycle of stimulus; expected post-edge state goes to the scoreboard
  task automatic step(input bit clr, ld, ce, up, input logic [7:0] d, db,
                      input bit glitch = 1'b0);
    logic [26:0] e;
    logic [26:0] got;
    bit          term, term_c;
    CLR = clr; LOAD = ld; CE = ce; UP = up; D = d; DB = db;
    #1;
    term   = ce && !ld && !clr && m_tc({24'd0, m_a}, 2, up);
    term_c = ce && !ld && !clr && m_tc({16'd0, m_c}, 4, up);
    chk("tc_a", tc_a, m_tc({24'd0, m_a}, 2, up));
    chk("ceo_a", ceo_a, term);
    chk("ceo_b_cascade", ceo_b, term_c);
    chk("tc_r", tc_r, m_tc({24'd0, m_a}, 2, up));
    if (glitch) begin
      CLR = 1'b1;
      #1;
      CLR = 1'b0;
    end
    m_a = 8'(m_next({24'd0, m_a}, 2, clr, ld, ce, up, {24'd0, d}));
    m_c = 16'(m_next({16'd0, m_c}, 4, clr, ld, ce, up, {16'd0, db, d}));
    m_err_a = !clr && ld && m_bad(d);
    m_err_b = !clr && ld && m_bad(db);
    m_ceor  = term;
    exp_q.push_back({m_a, m_err_a, m_err_b, m_ceor, m_c});
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    got = {q_a, lderr_a, lderr_b, ceo_r, q_b, q_a};
    chk("state", got, e);
    chk("q_r", {q_r, lderr_r}, {m_a, m_err_a});
    @(negedge CLK);
  endtask

  typedef struct {
    bit         clr, ld, ce, up;
    logic [7:0] d, db;
    logic [7:0] exp_q;
    bit         exp_err;
  } vec_t;

  vec_t tbl[14];

  initial begin
    CLR = 1'b1; LOAD = 1'b0; CE = 1'b0; UP = 1'b1; D = 8'h00; DB = 8'h00;
    m_a = 8'h00; m_c = 16'h0000; m_err_a = 0; m_err_b = 0; m_ceor = 0;
    @(negedge CLK);

    step(1, 0, 0, 1, 8'h00, 8'h00);
    chk("reset_q", q_a, 8'h00);
    chk("reset_lderr", lderr_a, 1'b0);
    chk("reset_ceo_r", ceo_r, 1'b0);

    // table-driven: down count, load validation, priority, direction change
    tbl[0]  = '{0, 1, 0, 1, 8'h01, 8'h00, 8'h01, 0};
    tbl[1]  = '{0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0};
    tbl[2]  = '{0, 0, 1, 0, 8'h00, 8'h00, 8'h99, 0};
    tbl[3]  = '{0, 0, 1, 0, 8'h00, 8'h00, 8'h98, 0};
    tbl[4]  = '{0, 1, 0, 1, 8'h3C, 8'h00, 8'h30, 1};
    tbl[5]  = '{0, 1, 1, 1, 8'h45, 8'hA5, 8'h45, 0};
    tbl[6]  = '{0, 0, 0, 1, 8'h00, 8'h00, 8'h45, 0};
    tbl[7]  = '{0, 0, 0, 1, 8'h00, 8'h00, 8'h45, 0};
    tbl[8]  = '{0, 0, 1, 1, 8'h00, 8'h00, 8'h46, 0};
    tbl[9]  = '{1, 1, 1, 1, 8'h77, 8'h00, 8'h00, 0};
    tbl[10] = '{0, 1, 0, 1, 8'hF9, 8'h00, 8'h09, 1};
    tbl[11] = '{0, 0, 1, 1, 8'h00, 8'h00, 8'h10, 0};
    tbl[12] = '{0, 1, 0, 1, 8'h09, 8'h00, 8'h09, 0};
    tbl[13] = '{0, 0, 1, 0, 8'h00, 8'h00, 8'h08, 0};
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].clr, tbl[i].ld, tbl[i].ce, tbl[i].up, tbl[i].d, tbl[i].db);
      chk("tbl_q", q_a, tbl[i].exp_q);
      chk("tbl_lderr", lderr_a, tbl[i].exp_err);
    end

    // full up sweep 00..99, hold at 99, then wrap
    step(1, 0, 0, 1, 8'h00, 8'h00);
    for (int i = 0; i < 99; i++) step(0, 0, 1, 1, 8'h00, 8'h00);
    chk("sweep_99", q_a, 8'h99);
    step(0, 0, 0, 1, 8'h00, 8'h00);
    chk("hold_99", q_a, 8'h99);
    step(0, 0, 1, 1, 8'h00, 8'h00);
    chk("wrap_00", q_a, 8'h00);
    chk("ceo_r_after_wrap", ceo_r, 1'b1);
    step(0, 0, 0, 1, 8'h00, 8'h00);
    chk("ceo_r_one_cycle", ceo_r, 1'b0);

    // cascade 9999 -> 0000 in one edge, then back down
    step(0, 1, 0, 1, 8'h99, 8'h99);
    step(0, 0, 1, 1, 8'h00, 8'h00);
    chk("cascade_wrap", {q_b, q_a}, 16'h0000);
    step(0, 0, 1, 0, 8'h00, 8'h00);
    chk("cascade_down", {q_b, q_a}, 16'h9999);

    // mid-count reset, and a CLR pulse between edges that must be ignored
    step(0, 1, 0, 1, 8'h56, 8'h00);
    step(0, 0, 1, 1, 8'h00, 8'h00);
    chk("count_57", q_a, 8'h57);
    step(1, 0, 1, 1, 8'h00, 8'h00);
    chk("clr_midcount", q_a, 8'h00);
    step(0, 0, 1, 1, 8'h00, 8'h00, 1'b1);
    chk("clr_glitch_ignored", q_a, 8'h01);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 40) == 0, $urandom_range(0, 12) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0,
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_cnt_n.md
Name: bcd_cnt_n

Overview:
Parametrised multi-decade synchronous BCD counter, successor to the single-decade CE/CEO counter.
- All decades share one clock. Carries propagate as per-digit clock enables, never as derived clocks, so there is no inter-stage skew.
- Adds up/down counting, synchronous parallel load with BCD validation, and terminal-count outputs for cascading further instances.
- Used in lab timing/display chains (stopwatch, frequency meter) feeding 7-segment decoders.

Parameters:
DIGITS, 2, number of BCD decades (1..8); counter width is 4*DIGITS bits.
CEO_REG, 0, 0 = combinational CEO; 1 = CEO registered (one-cycle-late pulse, see Behaviour).

Ports:
CLK  in  1  system clock; all state changes on rising edge.
CLR  in  1  reset; synchronous, active-high, highest priority.
CE  in  1  count enable for the least significant decade.
UP  in  1  direction: 1 = count up, 0 = count down; sampled each cycle.
LOAD  in  1  synchronous parallel load of D; overrides CE.
D  in  4*DIGITS  load value, digit i at bits [4i+3:4i], digit 0 = LSD.
Q  out  4*DIGITS  counter value, same digit packing as D.
TC  out  1  terminal count, unqualified: UP=1 and Q all 9s, or UP=0 and Q all 0s.
CEO  out  1  cascade enable to the next instance.
LD_ERR  out  1  one-cycle pulse: previous cycle's load contained a digit >9.

Behaviour:
Reset:
- One clock; reset is synchronous and active-high (CLR, sampled on CLK rising edge).
- CLR=1 at an edge gives Q=0, LD_ERR=0, registered CEO=0.
- CLR overrides LOAD and CE; an operation in progress is abandoned with no residual state.

Priority per edge: CLR > LOAD > CE.

Load (LOAD=1):
- Each digit of D is written to Q regardless of CE.
- Any digit in A..F is written as 0; LD_ERR=1 in the next cycle, otherwise LD_ERR=0.
- LOAD and CE both high: load wins and no count occurs.

Count (CE=1, LOAD=0):
- Digit enable chain: en[0]=CE; en[i]=en[i-1] & digit_tc[i-1].
- digit_tc is Q[i]==9 when UP=1, Q[i]==0 when UP=0.
- An enabled digit steps +1 when UP=1, wrapping 9->0, or -1 when UP=0, wrapping 0->9.
- Latency is one cycle from CE to the Q update.

Full-scale wrap:
- Up: all 9s -> all 0s.
- Down: all 0s -> all 9s.
- TC is high in the cycle before the wrap edge.

CEO:
- CEO_REG=0: CEO = CE & ~LOAD & ~CLR & TC, combinational. It is high exactly in the cycle whose edge wraps the whole counter.
- CEO_REG=1: CEO is that same term registered, so it is high in the cycle after the wrap edge. It is cleared by CLR.
- Cascade only the CEO_REG=0 form into a downstream CE for exact synchrony.

Direction change:
- UP changing mid-count takes effect on the same edge.
- Example: Q=09, UP goes 1->0 with CE=1 gives Q=08.

Invalid contents: Q cannot hold a non-BCD digit, because load sanitises and arithmetic wraps.

No combinational path from Q to Q; the enable chain depth is DIGITS-1 AND gates.

Decomposition:
- Shared package bcd_pkg:
  - constant BCD_MAX=4'd9, BCD_MIN=4'd0
  - function bcd_valid(d)
  - function bcd_step(d, up) returning the next digit
- Natural sub-module: bcd_digit, one decade with inputs CLK, CLR, EN, UP, LOAD, D and outputs Q, DTC, DERR.
- bcd_cnt_n instantiates DIGITS copies in a generate loop, builds the enable chain, ORs DERR into LD_ERR, and forms TC/CEO.

Test Plan:
1. DIGITS=2, CLR then CE=1, UP=1 for 100 cycles -> Q steps 00..99. TC=CEO=1 only while Q=99; the next edge gives Q=00. Digit 1 increments only at the 09->10, 19->20, ... edges.
2. CE toggling: CE=0 for 3 cycles at Q=45 -> Q holds 45 and CEO=0. CE=0 at Q=99 -> TC=1, CEO=0.
3. Down count: LOAD D=0x01, then CE=1, UP=0 -> 01, 00 (TC=CEO=1), 99, 98. With UP=1 at Q=00, TC=0.
4. Load validation: LOAD D=0x3C -> Q=30 and LD_ERR=1 for one cycle. LOAD with CE=1 -> no count. CLR with LOAD=1 -> Q=00.
5. Cascade: two DIGITS=2 instances, second CE = first CEO, common CLK. Count 9999 -> 0000 in one edge with no intermediate values. CEO_REG=1 variant: registered CEO is high the cycle after Q=00 appears.
6. Mid-operation reset: CLR asserted at Q=57 while counting -> Q=00 on that edge. CLR held low between edges has no effect (synchronous).
